// File: rtl/tone_period_meter_if.sv
// Tone measurement bus: the tone line into the meter and the measured results out of it.
// Ports: tone_in (tone line); period, half_high, period_valid, present, sweep_up, sweep_down (results).
interface tone_period_meter_if #(
  parameter int CNT_W = 20
);
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] half_high;
  logic             period_valid;
  logic             present;
  logic             sweep_up;
  logic             sweep_down;

  modport master (
    output tone_in,
    input  period,
    input  half_high,
    input  period_valid,
    input  present,
    input  sweep_up,
    input  sweep_down
  );

  modport slave (
    input  tone_in,
    output period,
    output half_high,
    output period_valid,
    output present,
    output sweep_up,
    output sweep_down
  );
endinterface

// File: rtl/tone_period_meter.sv
// Tone period meter: syncs and deglitches a square wave, then measures period, high time and sweep.
// Ports: clk, rst (async, active high); bus (slave): tone_in in, period/half_high/flags out.
module tone_period_meter #(
  parameter int CNT_W    = 20,
  parameter int FILT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tone_period_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [7:0] r_fcnt;
  logic       r_filt;
  logic       r_filt_d;
  logic       r_rise;
  logic       r_fall;

  // Front end: 2-flop sync, hold filter, registered edge strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_fcnt   <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1  <= bus.tone_in;
      r_sync2  <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FILT_LAST) begin
        r_filt <= ~r_filt;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
      r_filt_d <= r_filt;
      r_rise   <= r_filt & ~r_filt_d;
      r_fall   <= ~r_filt & r_filt_d;
    end
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_half;
  logic             r_pv;
  logic             r_present;
  logic             r_up;
  logic             r_down;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_hi;
  logic [CNT_W-1:0] w_prev;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_half;
  logic             w_pv;
  logic             w_present;
  logic             w_up;
  logic             w_down;

  // ARMED = first period after IDLE, no previous period to compare.
  // MEASURE = a previous period is held, so sweep flags are meaningful.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_hi      = r_hi;
    w_prev    = r_prev;
    w_period  = r_period;
    w_half    = r_half;
    w_pv      = 1'b0;
    w_present = r_present;
    w_up      = r_up;
    w_down    = r_down;
    unique case (r_state)
      IDLE: begin
        if (r_rise) begin
          w_cnt   = CNT_ONE;
          w_hi    = '0;
          w_state = ARMED;
        end
      end
      ARMED, MEASURE: begin
        w_cnt = r_cnt + CNT_ONE;
        if (r_fall) begin
          w_hi = r_cnt;
        end
        // A rise beats a timeout landing in the same cycle.
        if (r_rise) begin
          w_period  = r_cnt;
          w_half    = r_hi;
          w_pv      = 1'b1;
          w_cnt     = CNT_ONE;
          w_prev    = r_cnt;
          w_present = 1'b1;
          w_up      = (r_state == MEASURE) && (r_cnt < r_prev);
          w_down    = (r_state == MEASURE) && (r_cnt > r_prev);
          w_state   = MEASURE;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt     = '0;
          w_present = 1'b0;
          w_up      = 1'b0;
          w_down    = 1'b0;
          w_state   = IDLE;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_prev    <= '0;
      r_period  <= '0;
      r_half    <= '0;
      r_pv      <= 1'b0;
      r_present <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_hi      <= w_hi;
      r_prev    <= w_prev;
      r_period  <= w_period;
      r_half    <= w_half;
      r_pv      <= w_pv;
      r_present <= w_present;
      r_up      <= w_up;
      r_down    <= w_down;
    end
  end

  assign bus.period       = r_period;
  assign bus.half_high    = r_half;
  assign bus.period_valid = r_pv;
  assign bus.present      = r_present;
  assign bus.sweep_up     = r_up;
  assign bus.sweep_down   = r_down;

endmodule

// File: tb/tb_tone_period_meter.sv
// Testbench for tone_period_meter: table of waveform phases with expected readings,
// plus directed timeout, restart and mid-period reset sequences.
module tb_tone_period_meter;
  localparam int CW  = 12;
  localparam int FL  = 4;
  localparam int LAT = 2 + FL + 1;
  localparam int TMO = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_period_meter_if #(.CNT_W(CW)) bus ();

  tone_period_meter #(
    .CNT_W   (CW),
    .FILT_LEN(FL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_chg = 0;
  int fall_chg = 0;
  bit lat_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int hi;
    int lo;
    int g_at;
    int g_len;
    int e_per;
    int e_hi;
    bit e_up;
    bit e_dn;
  } vec_t;

  typedef struct {
    int per;
    int hi;
    bit up;
    bit dn;
    bit pres;
    int c;
  } rep_t;

  vec_t tbl[16];
  rep_t reps[$];

  task automatic check(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.period_valid)
      reps.push_back('{int'(bus.period), int'(bus.half_high),
                       bus.sweep_up, bus.sweep_down, bus.present, cyc});
  end

  always @(negedge clk) begin
    if (lat_en) begin
      if (dut.r_rise) check("rise_latency", cyc - rise_chg, LAT);
      if (dut.r_fall) check("fall_latency", cyc - fall_chg, LAT);
    end
  end

  // Called at posedge+1; returns at posedge+1 after n cycles.
  task automatic drive(bit lvl, int n);
    if (lvl != bus.tone_in) begin
      if (lvl) rise_chg = cyc;
      else     fall_chg = cyc;
    end
    bus.tone_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_period"},  int'(bus.period), 0);
    check({tag, "_half"},    int'(bus.half_high), 0);
    check({tag, "_pv"},      int'(bus.period_valid), 0);
    check({tag, "_present"}, int'(bus.present), 0);
    check({tag, "_up"},      int'(bus.sweep_up), 0);
    check({tag, "_down"},    int'(bus.sweep_down), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int last_pv;
    int t;
    int r2;
    int nr;

    for (int i = 0; i < 5; i++) tbl[i] = '{500, 500, 0, 0, 1000, 500, 0, 0};
    tbl[5]  = '{500, 500, 250, 3, 1000, 500, 0, 0};
    tbl[6]  = '{500, 500, 100, 3, 1000, 500, 0, 0};
    tbl[7]  = '{500, 250,   0, 0,  750, 500, 1, 0};
    tbl[8]  = '{  4, 246,   0, 0,  250,   4, 1, 0};
    tbl[9]  = '{500, 500,   0, 0, 1000, 500, 0, 1};
    tbl[10] = '{450, 450,   0, 0,  900, 450, 1, 0};
    tbl[11] = '{450, 450,   0, 0,  900, 450, 0, 0};
    tbl[12] = '{550, 550,   0, 0, 1100, 550, 0, 1};
    tbl[13] = '{ 16,  48,   0, 0,   64,  16, 1, 0};
    tbl[14] = '{ 16,  48,   0, 0,   64,  16, 0, 0};
    tbl[15] = '{ 16,  48,   0, 0,   64,  16, 0, 0};

    rst = 1'b1;
    bus.tone_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    lat_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tbl[i].hi);
      if (tbl[i].g_len != 0) begin
        drive(1'b0, tbl[i].g_at);
        drive(1'b1, tbl[i].g_len);
        drive(1'b0, tbl[i].lo - tbl[i].g_at - tbl[i].g_len);
      end else begin
        drive(1'b0, tbl[i].lo);
      end
    end
    drive(1'b1, 500);
    drive(1'b0, 0);

    check("table_reports", reps.size(), 16);
    nr = (reps.size() < 16) ? reps.size() : 16;
    for (int i = 0; i < nr; i++) begin
      check($sformatf("v%0d_period", i),  reps[i].per, tbl[i].e_per);
      check($sformatf("v%0d_half", i),    reps[i].hi, tbl[i].e_hi);
      check($sformatf("v%0d_up", i),      int'(reps[i].up), int'(tbl[i].e_up));
      check($sformatf("v%0d_down", i),    int'(reps[i].dn), int'(tbl[i].e_dn));
      check($sformatf("v%0d_present", i), int'(reps[i].pres), 1);
    end

    // Line held low: present must drop exactly TMO clocks after the last report.
    n0 = reps.size();
    last_pv = (n0 > 0) ? reps[n0-1].c : 0;
    t = 0;
    while (bus.present && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_present", int'(bus.present), 0);
    check("timeout_delay", cyc - last_pv, TMO);
    check("timeout_up", int'(bus.sweep_up), 0);
    check("timeout_down", int'(bus.sweep_down), 0);
    repeat (50) @(negedge clk);
    check("timeout_no_pv", reps.size(), n0);
    @(posedge clk);
    #1;

    // Restart: first reading after IDLE never carries a sweep flag.
    n0 = reps.size();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 200);
      drive(1'b0, 200);
    end
    drive(1'b1, 100);
    drive(1'b0, 50);
    check("restart_reports", reps.size() - n0, 3);
    for (int i = n0; i < reps.size() && i < n0 + 3; i++) begin
      check($sformatf("restart%0d_period", i - n0), reps[i].per, 400);
      check($sformatf("restart%0d_half", i - n0), reps[i].hi, 200);
      check($sformatf("restart%0d_up", i - n0), int'(reps[i].up), 0);
      check($sformatf("restart%0d_down", i - n0), int'(reps[i].dn), 0);
      check($sformatf("restart%0d_present", i - n0), int'(reps[i].pres), 1);
    end

    // Reset pulse in the low phase of a running measurement.
    drive(1'b1, 200);
    drive(1'b0, 100);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = reps.size();
    drive(1'b0, 99);
    drive(1'b1, 200);
    check("rst_no_pv_after_rise1", reps.size() - n0, 0);
    check("rst_present_after_rise1", int'(bus.present), 0);
    drive(1'b0, 200);
    drive(1'b1, 50);
    r2 = rise_chg;
    drive(1'b0, 20);
    check("rst_pv_after_rise2", reps.size() - n0, 1);
    if (reps.size() > n0) begin
      check("rst_period", reps[n0].per, 400);
      check("rst_half", reps[n0].hi, 200);
      check("rst_up", int'(reps[n0].up), 0);
      check("rst_down", int'(reps[n0].dn), 0);
      check("rst_present", int'(reps[n0].pres), 1);
      check("rst_pv_latency", reps[n0].c - r2, LAT + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
